// File: rtl/uart_alu_intf.sv
// uart_alu_intf: gathers operand A, operand B and opcode bytes from the UART
// receiver, strobes the combinational ALU, and hands the result byte to the
// UART transmitter before waiting for its completion pulse.
// Optional build macro: UART_ALU_TIMEOUT_EN enables an inter-byte timeout that
// abandons a partial frame after TIMEOUT_CYCLES idle clocks.
module uart_alu_intf #(
    parameter int unsigned         NB_DATA        = 8,
    parameter int unsigned         NB_OP          = 6,
    parameter logic [NB_DATA-1:0]  ERR_CODE       = 8'hFF,
    parameter int unsigned         TIMEOUT_CYCLES = 50000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_alu_valid,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'h20);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'h22);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'h24);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'h25);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'h26);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'h03);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'h02);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'h27);

    state_t             state;
    state_t             state_next;
    logic [NB_DATA-1:0] dato_a_next;
    logic [NB_DATA-1:0] dato_b_next;
    logic [NB_OP-1:0]   operation_next;
    logic [NB_DATA-1:0] tx_data_next;
    logic [NB_OP-1:0]   rx_opcode;
    logic               op_supported;
    logic               expired;

    assign rx_opcode = i_rx_data[NB_OP-1:0];

`ifdef UART_ALU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] idle_cnt;
    logic             in_frame;

    assign in_frame = (state == WAIT_B) || (state == WAIT_OP);
    // A byte arriving on the expiry cycle wins, so expiry requires no i_rx_done.
    assign expired  = in_frame && !i_rx_done && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: counts only while mid-frame, clears on accepted bytes and expiry.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idle_cnt <= '0;
        end else if (in_frame && !i_rx_done && !expired) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    // Without the timeout build the partial frame waits forever.
    assign expired = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // Opcode decode: membership in the supported ALU operation set.
    always_comb begin
        op_supported = 1'b0;
        case (rx_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_supported = 1'b1;
            default:                        op_supported = 1'b0;
        endcase
    end

    // Next-state and next-register-value logic for the frame sequencer.
    always_comb begin
        state_next     = state;
        dato_a_next    = o_datoA;
        dato_b_next    = o_datoB;
        operation_next = o_operation;
        tx_data_next   = o_tx_data;
        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    dato_a_next = i_rx_data;
                    state_next  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    dato_b_next = i_rx_data;
                    state_next  = WAIT_OP;
                end else if (expired) begin
                    state_next = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    operation_next = rx_opcode;
                    if (op_supported) begin
                        state_next = EXEC;
                    end else begin
                        tx_data_next = ERR_CODE;
                        state_next   = SEND;
                    end
                end else if (expired) begin
                    state_next = WAIT_A;
                end
            end
            EXEC: begin
                tx_data_next = i_alu_result;
                state_next   = SEND;
            end
            SEND: begin
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // Operand, opcode and TX byte registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_datoA     <= '0;
            o_datoB     <= '0;
            o_operation <= '0;
            o_tx_data   <= '0;
        end else begin
            o_datoA     <= dato_a_next;
            o_datoB     <= dato_b_next;
            o_operation <= operation_next;
            o_tx_data   <= tx_data_next;
        end
    end

    assign o_alu_valid = (state == EXEC);
    assign o_tx_start  = (state == SEND);
    assign o_busy      = (state != WAIT_A);

endmodule

// File: tb/tb_uart_alu_intf.sv
// Testbench for uart_alu_intf: UART modelled by pulses, ALU modelled
// behaviourally; expected results come from a reference model of the ALU op set.
module tb_uart_alu_intf;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] i_alu_result;
    logic [7:0] o_datoA;
    logic [7:0] o_datoB;
    logic [5:0] o_operation;
    logic       o_alu_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;

    int n_cmp = 0;
    int n_fail = 0;
    int valid_pulses = 0;

    always #5 i_clk = ~i_clk;

    uart_alu_intf #(
        .NB_DATA(8),
        .NB_OP(6),
        .ERR_CODE(8'hFF),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_rx_data(i_rx_data),
        .i_rx_done(i_rx_done),
        .i_tx_done(i_tx_done),
        .i_alu_result(i_alu_result),
        .o_datoA(o_datoA),
        .o_datoB(o_datoB),
        .o_operation(o_operation),
        .o_alu_valid(o_alu_valid),
        .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start),
        .o_busy(o_busy)
    );

    // Combinational ALU stand-in driven by the DUT operand/opcode registers.
    always_comb begin
        case (o_operation)
            6'h20:   i_alu_result = o_datoA + o_datoB;
            6'h22:   i_alu_result = o_datoA - o_datoB;
            6'h24:   i_alu_result = o_datoA & o_datoB;
            6'h25:   i_alu_result = o_datoA | o_datoB;
            6'h26:   i_alu_result = o_datoA ^ o_datoB;
            6'h03:   i_alu_result = $signed(o_datoA) >>> o_datoB;
            6'h02:   i_alu_result = o_datoA >> o_datoB;
            6'h27:   i_alu_result = ~(o_datoA | o_datoB);
            default: i_alu_result = 8'h00;
        endcase
    end

    always @(negedge i_clk) if (o_alu_valid) valid_pulses++;

    // Reference: {supported, byte to transmit} from the three received bytes.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
        logic [7:0] r;
        int unsigned sh;
        sh = b;
        case (opb & 8'h3F)
            8'h20: r = 8'((int'(a) + int'(b)) % 256);
            8'h22: r = 8'((int'(a) - int'(b) + 256) % 256);
            8'h24: r = a & b;
            8'h25: r = a | b;
            8'h26: r = a ^ b;
            8'h03: r = (sh >= 8) ? {8{a[7]}} : 8'((int'($signed(a))) / (1 << sh) - ((int'($signed(a)) < 0 && (int'($signed(a)) % (1 << sh)) != 0) ? 1 : 0));
            8'h02: r = (sh >= 8) ? 8'h00 : 8'(int'(a) / (1 << sh));
            8'h27: r = 8'hFF ^ (a | b);
            default: return {1'b0, 8'hFF};
        endcase
        return {1'b1, r};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                             input bit skip_a, input bit early_done, input bit drop_byte, input string nm);
        logic [8:0] exp;
        int vp0;
        exp = model(a, b, opb);
        vp0 = valid_pulses;
        if (!skip_a) send_byte(a);
        send_byte(b);
        send_byte(opb);
        n_cmp++; if (o_alu_valid !== exp[8]) begin n_fail++; $display("FAIL %s alu_valid: got %b want %b", nm, o_alu_valid, exp[8]); end
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_exec: got %b want 1", nm, o_busy); end
        n_cmp++; if (o_datoA !== a) begin n_fail++; $display("FAIL %s datoA: got %h want %h", nm, o_datoA, a); end
        n_cmp++; if (o_datoB !== b) begin n_fail++; $display("FAIL %s datoB: got %h want %h", nm, o_datoB, b); end
        n_cmp++; if (o_operation !== opb[5:0]) begin n_fail++; $display("FAIL %s operation: got %h want %h", nm, o_operation, opb[5:0]); end
        if (exp[8]) begin
            n_cmp++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL %s tx_start_early: got %b want 0", nm, o_tx_start); end
            @(negedge i_clk);
        end
        n_cmp++; if (o_tx_start !== 1'b1) begin n_fail++; $display("FAIL %s tx_start: got %b want 1", nm, o_tx_start); end
        n_cmp++; if (o_tx_data !== exp[7:0]) begin n_fail++; $display("FAIL %s tx_data: got %h want %h", nm, o_tx_data, exp[7:0]); end
        n_cmp++; if (o_alu_valid !== 1'b0) begin n_fail++; $display("FAIL %s alu_valid_send: got %b want 0", nm, o_alu_valid); end
        if (early_done) i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        n_cmp++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL %s tx_start_once: got %b want 0", nm, o_tx_start); end
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_wait_tx: got %b want 1", nm, o_busy); end
        if (drop_byte) begin
            send_byte(8'h55);
            n_cmp++; if (o_busy !== 1'b1 || o_datoA !== a) begin n_fail++; $display("FAIL %s drop: got busy=%b A=%h want busy=1 A=%h", nm, o_busy, o_datoA, a); end
        end
        repeat ($urandom_range(0, 3)) @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_done: got %b want 0", nm, o_busy); end
        n_cmp++; if (o_tx_data !== exp[7:0]) begin n_fail++; $display("FAIL %s tx_hold: got %h want %h", nm, o_tx_data, exp[7:0]); end
        n_cmp++; if (valid_pulses - vp0 !== int'(exp[8])) begin n_fail++; $display("FAIL %s valid_count: got %0d want %0d", nm, valid_pulses - vp0, exp[8]); end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_rx_data = 8'h00; i_rx_done = 1'b0; i_tx_done = 1'b0;
        repeat (2) @(negedge i_clk);
        n_cmp++; if ({o_datoA, o_datoB, o_operation, o_alu_valid, o_tx_data, o_tx_start, o_busy} !== 35'd0) begin
            n_fail++; $display("FAIL reset_outputs: got A=%h B=%h op=%h v=%b tx=%h st=%b busy=%b want all 0",
                               o_datoA, o_datoB, o_operation, o_alu_valid, o_tx_data, o_tx_start, o_busy); end
        i_reset = 1'b0;
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_tx_done: got busy %b want 0", o_busy); end
    endtask

    task automatic test_directed();
        run_frame(8'h05, 8'h03, 8'h20, 0, 1, 0, "add");
        run_frame(8'hF0, 8'h02, 8'h03, 0, 0, 0, "sra");
        run_frame(8'h0F, 8'hF0, 8'h27, 0, 0, 0, "nor");
        run_frame(8'h01, 8'h02, 8'h3F, 0, 0, 0, "invalid");
        run_frame(8'h05, 8'h03, 8'hE0, 0, 0, 0, "op_upper_bits");
    endtask

    task automatic test_back_to_back();
        run_frame(8'h10, 8'h20, 8'h25, 0, 0, 1, "drop_in_wait_tx");
        run_frame(8'h01, 8'h01, 8'h20, 0, 0, 0, "after_drop");
    endtask

    task automatic test_mid_reset();
        send_byte(8'h07);
        n_cmp++; if (o_busy !== 1'b1 || o_datoA !== 8'h07) begin n_fail++; $display("FAIL partial_a: got busy=%b A=%h want 1 07", o_busy, o_datoA); end
        #2 i_reset = 1'b1;
        #1;
        n_cmp++; if (o_busy !== 1'b0 || o_datoA !== 8'h00) begin n_fail++; $display("FAIL async_reset: got busy=%b A=%h want 0 00", o_busy, o_datoA); end
        @(negedge i_clk);
        i_reset = 1'b0;
        run_frame(8'h02, 8'h03, 8'h22, 0, 0, 0, "sub_after_reset");
    endtask

    task automatic test_idle_frame();
        int vp0;
        vp0 = valid_pulses;
        send_byte(8'h09);
        repeat (120) @(negedge i_clk);
`ifdef UART_ALU_TIMEOUT_EN
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_datoA !== 8'h09 || valid_pulses != vp0) begin n_fail++; $display("FAIL timeout_outputs: got A=%h pulses=%0d want 09 0", o_datoA, valid_pulses - vp0); end
        run_frame(8'h04, 8'h04, 8'h24, 0, 0, 0, "and_after_timeout");
`else
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL no_timeout_busy: got %b want 1", o_busy); end
        n_cmp++; if (o_datoA !== 8'h09 || valid_pulses != vp0) begin n_fail++; $display("FAIL no_timeout_outputs: got A=%h pulses=%0d want 09 0", o_datoA, valid_pulses - vp0); end
        run_frame(8'h09, 8'h04, 8'h24, 1, 0, 0, "and_after_idle");
`endif
    endtask

    task automatic test_random();
        logic [7:0] valid_ops [8];
        logic [7:0] a, b, opb, op;
        bit found;
        valid_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
        for (int unsigned i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                do begin
                    op = 8'($urandom_range(0, 63));
                    found = 1'b0;
                    for (int unsigned k = 0; k < 8; k++) if (valid_ops[k] == op) found = 1'b1;
                end while (found);
            end else begin
                op = valid_ops[$urandom_range(0, 7)];
            end
            opb = {2'($urandom), op[5:0]};
            run_frame(a, b, opb, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_idle_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
